fw_out_collector: RTL

//  Receiving end of the fw output stream: captures outD/out_valid words, buffers

---
 rtl/fw_out_collector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fw_out_collector.sv
// fw_out_collector: receiving end of the fw output stream.
// Captures in_data/in_valid words into a FIFO, throttles the array through
// inhibit with hysteresis, and drains words to a downstream reader with
// block sop/eop framing.
//
// Handshake: a word moves downstream on every rising edge where
// out_valid && out_ready are both high; while out_valid is high and
// out_ready is low, out_data/out_sop/out_eop hold their values. The
// upstream side has no ready: a word is taken whenever in_valid is high
// and there is room (or a pop frees room in the same cycle).
//
// The output register is a first-word-fall-through stage. fill counts every
// word not yet popped, including the one held in the output register.
module fw_out_collector #(
  parameter int DW    = 64,
  parameter int DEPTH = 16,
  parameter int SLACK = 4,
  parameter int WORDS = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int FW   = AW + 1,
  localparam int CW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          inhibit,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic          blk_done,
  output logic          overflow,
  output logic [FW-1:0] fill,
  output logic          dbg_state,
  output logic [CW-1:0] dbg_ic
);

  // EMPTY: nothing presented. The load of the head word happens on the
  // EMPTY->PRESENT edge, so the output stage has no separate wait state.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  logic [DW-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nx;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] oc_q, oc_d;
  logic [CW-1:0] ic_q, ic_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          inhibit_q, inhibit_d;
  logic          overflow_q, overflow_d;
  logic          blk_done_q, blk_done_d;

  logic          pop;
  logic          push;
  logic          full;

  assign pop       = (state_q == ST_PRESENT) && out_ready;
  assign full      = (fill_q == FW'(DEPTH));
  assign push      = in_valid && (!full || pop);
  assign rd_ptr_nx = rd_ptr_q + AW'(1);

  // Pointer, occupancy, counter and status next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    oc_d       = oc_q;
    ic_d       = ic_q;
    inhibit_d  = inhibit_q;
    overflow_d = overflow_q;
    blk_done_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      ic_d     = (ic_q == CW'(WORDS - 1)) ? '0 : ic_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_nx;
      oc_d       = (oc_q == CW'(WORDS - 1)) ? '0 : oc_q + CW'(1);
      blk_done_d = (oc_q == CW'(WORDS - 1));
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    // A word that finds the FIFO full with no pop is lost.
    if (in_valid && full && !pop) begin
      overflow_d = 1'b1;
    end

    // Throttle with hysteresis: set near full, release at half full.
    if (fill_q >= FW'(DEPTH - SLACK)) begin
      inhibit_d = 1'b1;
    end else if (fill_q <= FW'(DEPTH / 2)) begin
      inhibit_d = 1'b0;
    end
  end

  // Output stage next-state: load the head word, advance on pop.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (fill_q != '0) begin
          state_d    = ST_PRESENT;
          out_data_d = mem_q[rd_ptr_q];
        end
      end
      ST_PRESENT: begin
        if (pop) begin
          if (fill_d != '0) begin
            // With one word left the follower is the word arriving now,
            // which is not yet in memory, so take it straight from input.
            out_data_d = (fill_q == FW'(1)) ? in_data : mem_q[rd_ptr_nx];
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Storage array; contents need no reset because fill gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // All control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      oc_q       <= '0;
      ic_q       <= '0;
      out_data_q <= '0;
      inhibit_q  <= 1'b0;
      overflow_q <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      oc_q       <= oc_d;
      ic_q       <= ic_d;
      out_data_q <= out_data_d;
      inhibit_q  <= inhibit_d;
      overflow_q <= overflow_d;
      blk_done_q <= blk_done_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign out_data  = out_data_q;
  assign out_sop   = out_valid && (oc_q == '0);
  assign out_eop   = out_valid && (oc_q == CW'(WORDS - 1));
  assign blk_done  = blk_done_q;
  assign overflow  = overflow_q;
  assign inhibit   = inhibit_q;
  assign fill      = fill_q;
  assign dbg_state = state_q;
  assign dbg_ic    = ic_q;

endmodule
